eltwise_dual_rd_dma: RTL and testbench

- Read-request generator and response tracker for the ElementWise engine.
- Walks the A and B input feature maps in the codebase's channel-group/line/pixel memory layout and issues paired burst read requests, A then B, for each chunk.
- Counts returned beats and pulses done when both operands are fully fetched.
- Sits between the register/config layer and the HBM read port that feeds the ElementWise datapath.

---
 rtl/eltwise_dual_rd_dma.sv | 228 ++++++++++++++++++++++
 tb/tb_eltwise_dual_rd_dma.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eltwise_dual_rd_dma.sv
// rtl/eltwise_dual_rd_dma.sv - paired A/B burst read-request generator and response tracker for ElementWise
// Optional stall counter output perf_stall_cycles enabled by macro ELTWISE_RD_PERF_EN.
module eltwise_dual_rd_dma #(
    parameter int ADDR_W          = 32,
    parameter int DIM_W           = 16,
    parameter int PIXEL_BYTES     = 64,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_ch_grp,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic [ADDR_W-1:0] cfg_surface_stride,
    input  logic [ADDR_W-1:0] cfg_line_stride,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_len,
    output logic              req_sel,
    input  logic              rsp_valid,
    input  logic              rsp_sel,
    input  logic              rsp_last,
`ifdef ELTWISE_RD_PERF_EN
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic              busy,
    output logic              done
);

    localparam int BEAT_W = 3 * DIM_W;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ_A, S_REQ_B, S_WAIT_RSP, S_DONE} state_t;

    state_t            state_q;
    logic [DIM_W-1:0]  cfg_h_q, cfg_w_q, cfg_ch_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q, surf_q, line_q;
    logic [DIM_W-1:0]  ch_q, h_q, w_off_q;
    logic [ADDR_W-1:0] surf_off_q, line_off_q;
    logic [CNT_W-1:0]  pairs_q;
    logic [BEAT_W-1:0] a_beats_q, b_beats_q;
    logic              req_valid_q, req_sel_q, busy_q, done_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [7:0]        req_len_q;
`ifdef ELTWISE_RD_PERF_EN
    logic [31:0]       perf_q;
`endif

    logic [DIM_W-1:0]  rem, cur_len, nxt_rem, nxt_len, first_len;
    logic              last_w, last_h, last_ch, last_chunk;
    logic [DIM_W-1:0]  ch_d, h_d, w_off_d;
    logic [ADDR_W-1:0] surf_off_d, line_off_d, cur_off, nxt_off;
    logic              req_hs, b_hs, retire, can_issue;
    logic [CNT_W-1:0]  pairs_d;
    logic [BEAT_W-1:0] total_beats;

    always_comb begin
        rem        = cfg_w_q - w_off_q;
        last_w     = rem <= DIM_W'(MAX_BURST);
        cur_len    = last_w ? rem : DIM_W'(MAX_BURST);
        last_h     = h_q == cfg_h_q - DIM_W'(1);
        last_ch    = ch_q == cfg_ch_q - DIM_W'(1);
        last_chunk = last_w & last_h & last_ch;

        // Advance the w-chunk, then line, then channel-group position.
        w_off_d    = w_off_q + cur_len;
        h_d        = h_q;
        ch_d       = ch_q;
        line_off_d = line_off_q;
        surf_off_d = surf_off_q;
        if (last_w) begin
            w_off_d = '0;
            if (last_h) begin
                h_d        = '0;
                line_off_d = '0;
                ch_d       = ch_q + DIM_W'(1);
                surf_off_d = surf_off_q + surf_q;
            end else begin
                h_d        = h_q + DIM_W'(1);
                line_off_d = line_off_q + line_q;
            end
        end

        nxt_rem   = cfg_w_q - w_off_d;
        nxt_len   = (nxt_rem > DIM_W'(MAX_BURST)) ? DIM_W'(MAX_BURST) : nxt_rem;
        first_len = (cfg_w > DIM_W'(MAX_BURST)) ? DIM_W'(MAX_BURST) : cfg_w;
        cur_off   = surf_off_q + line_off_q + ADDR_W'(w_off_q) * ADDR_W'(PIXEL_BYTES);
        nxt_off   = surf_off_d + line_off_d + ADDR_W'(w_off_d) * ADDR_W'(PIXEL_BYTES);

        req_hs      = req_valid_q & req_ready;
        b_hs        = req_hs & req_sel_q;
        retire      = busy_q & rsp_valid & rsp_last & rsp_sel & (pairs_q != '0);
        pairs_d     = pairs_q + CNT_W'(b_hs) - CNT_W'(retire);
        can_issue   = pairs_d < CNT_W'(MAX_OUTSTANDING);
        total_beats = BEAT_W'(cfg_h_q) * BEAT_W'(cfg_w_q) * BEAT_W'(cfg_ch_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cfg_h_q     <= '0;
            cfg_w_q     <= '0;
            cfg_ch_q    <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            surf_q      <= '0;
            line_q      <= '0;
            ch_q        <= '0;
            h_q         <= '0;
            w_off_q     <= '0;
            surf_off_q  <= '0;
            line_off_q  <= '0;
            pairs_q     <= '0;
            a_beats_q   <= '0;
            b_beats_q   <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ELTWISE_RD_PERF_EN
            perf_q      <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            pairs_q <= pairs_d;
            if (busy_q && rsp_valid) begin
                if (rsp_sel) b_beats_q <= b_beats_q + BEAT_W'(1);
                else         a_beats_q <= a_beats_q + BEAT_W'(1);
            end
`ifdef ELTWISE_RD_PERF_EN
            if ((req_valid_q && !req_ready) || (state_q == S_REQ_A && !req_valid_q))
                perf_q <= perf_q + 32'd1;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_h_q    <= cfg_h;
                        cfg_w_q    <= cfg_w;
                        cfg_ch_q   <= cfg_ch_grp;
                        a_base_q   <= cfg_a_base;
                        b_base_q   <= cfg_b_base;
                        surf_q     <= cfg_surface_stride;
                        line_q     <= cfg_line_stride;
                        ch_q       <= '0;
                        h_q        <= '0;
                        w_off_q    <= '0;
                        surf_off_q <= '0;
                        line_off_q <= '0;
                        a_beats_q  <= '0;
                        b_beats_q  <= '0;
                        busy_q     <= 1'b1;
`ifdef ELTWISE_RD_PERF_EN
                        perf_q     <= '0;
`endif
                        if (cfg_h == '0 || cfg_w == '0 || cfg_ch_grp == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q     <= S_REQ_A;
                            req_valid_q <= 1'b1;
                            req_sel_q   <= 1'b0;
                            req_addr_q  <= cfg_a_base;
                            req_len_q   <= 8'(first_len - DIM_W'(1));
                        end
                    end
                end
                S_REQ_A: begin
                    if (req_valid_q) begin
                        if (req_ready) begin
                            state_q    <= S_REQ_B;
                            req_sel_q  <= 1'b1;
                            req_addr_q <= b_base_q + cur_off;
                        end
                    end else if (can_issue) begin
                        // Held here with valid low while the outstanding window is full.
                        req_valid_q <= 1'b1;
                    end
                end
                S_REQ_B: begin
                    if (req_ready) begin
                        ch_q       <= ch_d;
                        h_q        <= h_d;
                        w_off_q    <= w_off_d;
                        surf_off_q <= surf_off_d;
                        line_off_q <= line_off_d;
                        if (last_chunk) begin
                            state_q     <= S_WAIT_RSP;
                            req_valid_q <= 1'b0;
                        end else begin
                            state_q     <= S_REQ_A;
                            req_valid_q <= can_issue;
                            req_sel_q   <= 1'b0;
                            req_addr_q  <= a_base_q + nxt_off;
                            req_len_q   <= 8'(nxt_len - DIM_W'(1));
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (pairs_q == '0 && a_beats_q == total_beats && b_beats_q == total_beats)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_len   = req_len_q;
    assign req_sel   = req_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef ELTWISE_RD_PERF_EN
    assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_eltwise_dual_rd_dma.sv
// tb/tb_eltwise_dual_rd_dma.sv - self-checking bench for eltwise_dual_rd_dma
module tb_eltwise_dual_rd_dma;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [15:0] cfg_h, cfg_w, cfg_ch_grp;
    logic [31:0] cfg_a_base, cfg_b_base, cfg_surface_stride, cfg_line_stride;
    logic        req_valid, req_ready, req_sel;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        rsp_valid, rsp_sel, rsp_last, busy, done;
`ifdef ELTWISE_RD_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    eltwise_dual_rd_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_ch_grp(cfg_ch_grp),
        .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base),
        .cfg_surface_stride(cfg_surface_stride), .cfg_line_stride(cfg_line_stride),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_sel(rsp_sel), .rsp_last(rsp_last),
`ifdef ELTWISE_RD_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .busy(busy), .done(done)
    );

    typedef struct packed {logic [31:0] addr; logic [7:0] len; logic sel;} req_t;
    typedef struct packed {logic sel; logic last;} beat_t;

    req_t        exp_q[$];
    beat_t       rsp_q[$];
    logic [31:0] acc_addr [0:63];
    logic [7:0]  acc_len  [0:63];
    logic        acc_sel  [0:63];
    int          acc_n, acc_b, outstanding, done_cnt, job_done0, cyc;
    int          start_cyc, done_cyc, first_req_cyc, ready_pct, perf_model;
    int          n_assert, n_fail;
    bit          model_busy, first_req_seen, rsp_hold, prev_pend, prev_done;
    bit          post_reset, inject_stray;
    req_t        prev_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Reference walk: ch outer, line middle, w-chunk inner; A then B for each chunk.
    task automatic build_expected(input int h, input int w, input int ch, input logic [31:0] ab,
                                  input logic [31:0] bb, input logic [31:0] ls, input logic [31:0] ss);
        logic [31:0] off;
        int len;
        exp_q.delete();
        for (int c = 0; c < ch; c++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x += 16) begin
                    len = (w - x > 16) ? 16 : w - x;
                    off = 32'(c) * ss + 32'(y) * ls + 32'(x) * 32'd64;
                    exp_q.push_back('{addr: ab + off, len: 8'(len - 1), sel: 1'b0});
                    exp_q.push_back('{addr: bb + off, len: 8'(len - 1), sel: 1'b1});
                end
    endtask

    task automatic start_job(input int h, input int w, input int ch, input logic [31:0] ab,
                             input logic [31:0] bb, input logic [31:0] ls, input logic [31:0] ss,
                             input int pct, input bit hold);
        @(posedge clk); #1;
        build_expected(h, w, ch, ab, bb, ls, ss);
        cfg_h = 16'(h); cfg_w = 16'(w); cfg_ch_grp = 16'(ch);
        cfg_a_base = ab; cfg_b_base = bb; cfg_line_stride = ls; cfg_surface_stride = ss;
        ready_pct = pct; rsp_hold = hold;
        acc_n = 0; acc_b = 0; job_done0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == job_done0; i++) @(posedge clk);
        check("done_seen", 64'(done_cnt != job_done0), 64'd1);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete(); rsp_q.delete();
            outstanding = 0; model_busy = 0; prev_pend = 0; prev_done = 0;
            req_ready = 0; rsp_valid = 0; rsp_sel = 0; rsp_last = 0;
            post_reset = 1;
        end else begin
            if (post_reset) begin
                check("reset_outputs", {req_valid, req_addr, req_len, req_sel, busy, done}, 64'd0);
                post_reset = 0;
            end
            if (prev_pend) check("req_stable", {req_valid, req_addr, req_len, req_sel}, {1'b1, prev_req});
            if (req_valid && !req_sel) check("outstanding_limit", 64'(outstanding < MO), 64'd1);
            if (done) begin
                check("done_single", 64'(prev_done), 64'd0);
                check("busy_low_at_done", 64'(busy), 64'd0);
                check("all_reqs_issued", 64'(exp_q.size()), 64'd0);
                check("all_beats_back", 64'(outstanding == 0 && rsp_q.size() == 0), 64'd1);
`ifdef ELTWISE_RD_PERF_EN
                check("perf_at_done", 64'(perf_stall_cycles), 64'(perf_model));
`endif
                done_cyc = cyc; done_cnt++; model_busy = 0;
            end else if (model_busy) begin
                check("busy_high", 64'(busy), 64'd1);
            end else begin
                check("idle_quiet", {busy, req_valid}, 64'd0);
            end
            if (req_valid && model_busy && !first_req_seen) begin
                first_req_seen = 1; first_req_cyc = cyc;
            end
            prev_done = done;

            rsp_valid = 0; rsp_sel = 0; rsp_last = 0;
            if (inject_stray) begin
                rsp_valid = 1; rsp_sel = 1; rsp_last = 1; inject_stray = 0;
            end else if (!rsp_hold && rsp_q.size() > 0) begin
                beat_t b;
                b = rsp_q.pop_front();
                rsp_valid = 1; rsp_sel = b.sel; rsp_last = b.last;
                if (b.sel && b.last) outstanding--;
            end

            req_ready = ($urandom_range(99, 0) < ready_pct);
            if (req_valid && !req_ready) perf_model++;
            else if (!req_valid && model_busy && exp_q.size() > 0) perf_model++;
            if (req_valid && req_ready) begin
                if (exp_q.size() == 0) begin
                    check("no_extra_req", 64'(req_valid & req_ready), 64'd0);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    check("req_fields", {req_addr, req_len, req_sel}, e);
                end
                if (acc_n < 64) begin
                    acc_addr[acc_n] = req_addr; acc_len[acc_n] = req_len; acc_sel[acc_n] = req_sel;
                end
                acc_n++;
                if (req_sel) begin outstanding++; acc_b++; end
                for (int i = 0; i <= int'(req_len); i++)
                    rsp_q.push_back('{sel: req_sel, last: (i == int'(req_len))});
                prev_pend = 0;
            end else begin
                prev_pend = req_valid;
                prev_req  = '{addr: req_addr, len: req_len, sel: req_sel};
            end

            if (!model_busy && start) begin
                model_busy = 1; start_cyc = cyc; perf_model = 0; first_req_seen = 0;
            end
        end
    end

    initial begin
        n_assert = 0; n_fail = 0; done_cnt = 0; cyc = 0; acc_n = 0; acc_b = 0;
        ready_pct = 100; rsp_hold = 0; inject_stray = 0; perf_model = 0;
        start = 0; cfg_h = 0; cfg_w = 0; cfg_ch_grp = 0;
        cfg_a_base = 0; cfg_b_base = 0; cfg_surface_stride = 0; cfg_line_stride = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Zero-size job
        start_job(5, 0, 1, 32'h0, 32'h100_0000, 32'd4096, 32'd20480, 100, 0);
        wait_done(20);
        check("zero_done_latency", 64'(done_cyc - start_cyc), 64'd2);
        check("zero_no_reqs", 64'(acc_n), 64'd0);

        // Basic job, with a start pulse and config change while busy
        start_job(5, 64, 1, 32'h0, 32'h100_0000, 32'd4096, 32'd20480, 100, 0);
        repeat (40) @(posedge clk);
        #1 cfg_w = 16'd3; cfg_a_base = 32'hDEAD_0000; start = 1;
        @(posedge clk); #1 start = 0;
        wait_done(5000);
        check("basic_req_count", 64'(acc_n), 64'd40);
        check("basic_b_count", 64'(acc_b), 64'd20);
        check("basic_first_latency", 64'(first_req_cyc - start_cyc), 64'd1);
        check("basic_len0", 64'(acc_len[0]), 64'd15);
        check("basic_a0", 64'(acc_addr[0]), 64'h0);
        check("basic_b0", 64'(acc_addr[1]), 64'h100_0000);
        check("basic_a1", 64'(acc_addr[2]), 64'h400);
        check("basic_a2", 64'(acc_addr[4]), 64'h800);
        check("basic_a3", 64'(acc_addr[6]), 64'hC00);
        check("basic_a4", 64'(acc_addr[8]), 64'h1000);
        check("basic_last_sel", 64'(acc_sel[39]), 64'd1);
`ifdef ELTWISE_RD_PERF_EN
        repeat (5) @(posedge clk);
        #1 check("perf_held", 64'(perf_stall_cycles), 64'(perf_model));
`endif

        // Partial chunk across two channel groups
        start_job(1, 20, 2, 32'h0, 32'h100_0000, 32'd4096, 32'd20480, 100, 0);
        wait_done(1000);
        check("part_req_count", 64'(acc_n), 64'd8);
        check("part_len0", 64'(acc_len[0]), 64'd15);
        check("part_len1", 64'(acc_len[2]), 64'd3);
        check("part_a1", 64'(acc_addr[2]), 64'h400);
        check("part_ch1_a", 64'(acc_addr[4]), 64'h5000);
        check("part_ch1_a1", 64'(acc_addr[6]), 64'h5400);
        check("part_ch1_len1", 64'(acc_len[6]), 64'd3);

        // Address wrap-around
        start_job(2, 8, 1, 32'hFFFF_FF00, 32'h4000, 32'h100, 32'h1000, 100, 0);
        wait_done(500);
        check("wrap_a1", 64'(acc_addr[2]), 64'h0);
        check("wrap_len", 64'(acc_len[2]), 64'd7);

        // Backpressure with responses withheld
        start_job(2, 64, 1, 32'h1_0000, 32'h2_0000, 32'd4096, 32'd20480, 30, 1);
        for (int i = 0; i < 1000 && acc_b < 4; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        check("bp_pairs_issued", 64'(acc_n), 64'd8);
        check("bp_valid_low", 64'(req_valid), 64'd0);
        rsp_hold = 0;
        wait_done(4000);
        check("bp_req_count", 64'(acc_n), 64'd16);
        ready_pct = 100;

        // Reset mid-job, stray response in IDLE, then a clean job
        start_job(2, 64, 1, 32'h0, 32'h8000, 32'd4096, 32'd20480, 100, 1);
        repeat (12) @(posedge clk);
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        rsp_hold = 0;
        repeat (2) @(posedge clk);
        #1 inject_stray = 1;
        repeat (3) @(posedge clk);
        start_job(1, 16, 1, 32'h3000, 32'h9000, 32'd4096, 32'd20480, 100, 0);
        wait_done(500);
        check("post_reset_req_count", 64'(acc_n), 64'd2);
        check("post_reset_a0", 64'(acc_addr[0]), 64'h3000);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
